gyro_fifo_packer: RTL

GYRO_FIFO_PACKER -- requirements
Module: gyro_fifo_packer

---
 rtl/gyro_fifo_packer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/gyro_fifo_packer.sv
// gyro_fifo_packer: captures a gyro X/Y/Z sample on each rising edge of
// sample_flag and writes it to a 32-bit FIFO as two words:
//   word0 = {x, y}, word1 = {z, tag16}.
// Samples that arrive while a pair is still pending are dropped and counted
// in a saturating counter.
// Optional feature: define GYRO_PACK_SEQ_EN to make tag16 a 16-bit sequence
// number (first pair after reset carries 0x0000); otherwise tag16 is zero.
module gyro_fifo_packer #(
  parameter int unsigned DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       gyro_x,
  input  logic [15:0]       gyro_y,
  input  logic [15:0]       gyro_z,
  input  logic              sample_flag,
  input  logic              fifo_full,
  output logic [31:0]       snd_data,
  output logic              snd_en,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND0 = 2'd1,
    SEND1 = 2'd2
  } state_t;

  localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

  state_t            r_state;
  logic              r_flag_d;
  logic [15:0]       r_x_hold;
  logic [15:0]       r_y_hold;
  logic [15:0]       r_z_hold;
  logic [DROP_W-1:0] r_drop_cnt;
  logic              w_sample_evt;
  logic [15:0]       w_tag;

  assign w_sample_evt = sample_flag & ~r_flag_d;

  // Delayed copy of sample_flag for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_flag_d <= 1'b0;
    else        r_flag_d <= sample_flag;
  end

  // Pair-sending state machine with sample capture in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_x_hold <= '0;
      r_y_hold <= '0;
      r_z_hold <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_sample_evt) begin
            r_x_hold <= gyro_x;
            r_y_hold <= gyro_y;
            r_z_hold <= gyro_z;
            r_state  <= SEND0;
          end
        end
        SEND0:   if (!fifo_full) r_state <= SEND1;
        SEND1:   if (!fifo_full) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Saturating count of samples that arrive while a pair is pending,
  // including an edge coinciding with the final word write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_sample_evt && (r_state != IDLE) && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + DROP_ONE;
    end
  end

`ifdef GYRO_PACK_SEQ_EN
  logic [15:0] r_seq;

  // Sequence number advances on each completed word1 write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq <= '0;
    end else if ((r_state == SEND1) && !fifo_full) begin
      r_seq <= r_seq + 16'd1;
    end
  end

  assign w_tag = r_seq;
`else
  assign w_tag = '0;
`endif

  // FIFO write strobe and data, zero whenever no write takes place
  always_comb begin
    snd_en   = 1'b0;
    snd_data = '0;
    case (r_state)
      SEND0: if (!fifo_full) begin
        snd_en   = 1'b1;
        snd_data = {r_x_hold, r_y_hold};
      end
      SEND1: if (!fifo_full) begin
        snd_en   = 1'b1;
        snd_data = {r_z_hold, w_tag};
      end
      default: ;
    endcase
  end

  assign busy     = (r_state != IDLE);
  assign drop_cnt = r_drop_cnt;

endmodule
